// File: rtl/multdiv_pkg.sv
// Shared types for the sequential multiply/divide unit: FSM states and opcode encoding.
package multdiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

endpackage

// File: rtl/multdiv_seq_step_counter.sv
// Iteration counter for multdiv_seq: synchronous clear/enable, terminal count at WIDTH-1.
module step_counter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign tc_o = (cnt_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/multdiv_seq.sv
// Sequential one-bit-per-cycle multiplier (Booth / shift-add) and restoring divider
// with a single result register set updated on entry to DONE.
module multdiv_seq
    import multdiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic             ctrl_SIGNED,
    output logic [WIDTH-1:0] data_result,
    output logic [WIDTH-1:0] data_remainder,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    state_e           state_q;
    logic             op_q;
    logic             sgn_q;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH:0]   acc_q;
    logic [WIDTH-1:0] lo_q;
    logic             qm1_q;
    logic             qneg_q;
    logic             rneg_q;
    logic             ovf_q;
    logic             iter_done_q;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] rem_q;
    logic             exc_q;
    logic             rdy_q;
    logic             busy_q;

    logic [WIDTH:0]   acc_d;
    logic [WIDTH-1:0] lo_d;
    logic             qm1_d;
    logic [WIDTH:0]   mcand_ext;
    logic [WIDTH:0]   acc_sum;
    logic [WIDTH:0]   shifted;

    logic             start;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic             cnt_en;
    logic             cnt_tc;
    logic [WIDTH:0]   hi_chk;
    logic             mul_exc;
    logic [WIDTH-1:0] div_quo;
    logic [WIDTH-1:0] div_rem;

    assign start = (state_q == IDLE) && (ctrl_MULT || ctrl_DIV);
    assign a_neg = ctrl_SIGNED & data_operandA[WIDTH-1];
    assign b_neg = ctrl_SIGNED & data_operandB[WIDTH-1];
    assign mag_a = magnitude(data_operandA, a_neg);
    assign mag_b = magnitude(data_operandB, b_neg);
    assign cnt_en = ((state_q == MULT) || (state_q == DIV)) && !iter_done_q;

    step_counter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_step_counter (
        .clk_i (clock),
        .rst_i (reset),
        .clr_i (start),
        .en_i  (cnt_en),
        .tc_o  (cnt_tc)
    );

    // One iteration: Booth/shift-add step for multiply, restoring step for divide.
    always_comb begin
        mcand_ext = sgn_q ? {mcand_q[WIDTH-1], mcand_q} : {1'b0, mcand_q};
        acc_sum   = acc_q;
        shifted   = {acc_q[WIDTH-1:0], lo_q[WIDTH-1]};
        acc_d     = acc_q;
        lo_d      = lo_q;
        qm1_d     = qm1_q;
        if (op_q == OP_MULT) begin
            if (sgn_q) begin
                case ({lo_q[0], qm1_q})
                    2'b01:   acc_sum = acc_q + mcand_ext;
                    2'b10:   acc_sum = acc_q - mcand_ext;
                    default: acc_sum = acc_q;
                endcase
            end else if (lo_q[0]) begin
                acc_sum = acc_q + mcand_ext;
            end
            acc_d = {sgn_q & acc_sum[WIDTH], acc_sum[WIDTH:1]};
            lo_d  = {acc_sum[0], lo_q[WIDTH-1:1]};
            qm1_d = lo_q[0];
        end else begin
            if (shifted >= {1'b0, mcand_q}) begin
                acc_d = shifted - {1'b0, mcand_q};
                lo_d  = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_d = shifted;
                lo_d  = {lo_q[WIDTH-2:0], 1'b0};
            end
        end
    end

    // Signed products must fit in WIDTH bits: top WIDTH+1 product bits all equal.
    assign hi_chk  = {acc_q[WIDTH-1:0], lo_q[WIDTH-1]};
    assign mul_exc = sgn_q ? !((&hi_chk) || !(|hi_chk)) : (|acc_q[WIDTH-1:0]);
    assign div_quo = magnitude(lo_q, qneg_q);
    assign div_rem = magnitude(acc_q[WIDTH-1:0], rneg_q);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            op_q        <= OP_MULT;
            sgn_q       <= 1'b0;
            mcand_q     <= '0;
            acc_q       <= '0;
            lo_q        <= '0;
            qm1_q       <= 1'b0;
            qneg_q      <= 1'b0;
            rneg_q      <= 1'b0;
            ovf_q       <= 1'b0;
            iter_done_q <= 1'b0;
            result_q    <= '0;
            rem_q       <= '0;
            exc_q       <= 1'b0;
            rdy_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            rdy_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        busy_q      <= 1'b1;
                        sgn_q       <= ctrl_SIGNED;
                        iter_done_q <= 1'b0;
                        acc_q       <= '0;
                        qm1_q       <= 1'b0;
                        if (ctrl_MULT) begin
                            op_q    <= OP_MULT;
                            mcand_q <= data_operandA;
                            lo_q    <= data_operandB;
                            state_q <= MULT;
                        end else if (data_operandB == '0) begin
                            op_q     <= OP_DIV;
                            result_q <= '0;
                            rem_q    <= data_operandA;
                            exc_q    <= 1'b1;
                            rdy_q    <= 1'b1;
                            state_q  <= DONE;
                        end else begin
                            op_q    <= OP_DIV;
                            mcand_q <= mag_b;
                            lo_q    <= mag_a;
                            qneg_q  <= a_neg ^ b_neg;
                            rneg_q  <= a_neg;
                            ovf_q   <= ctrl_SIGNED && (data_operandA == MIN_VAL) &&
                                       (&data_operandB);
                            state_q <= DIV;
                        end
                    end
                end
                MULT, DIV: begin
                    if (iter_done_q) begin
                        if (op_q == OP_MULT) begin
                            result_q <= lo_q;
                            rem_q    <= '0;
                            exc_q    <= mul_exc;
                        end else begin
                            result_q <= div_quo;
                            rem_q    <= div_rem;
                            exc_q    <= ovf_q;
                        end
                        rdy_q   <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        acc_q <= acc_d;
                        lo_q  <= lo_d;
                        qm1_q <= qm1_d;
                        if (cnt_tc) begin
                            iter_done_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign data_result    = result_q;
    assign data_remainder = rem_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_multdiv_seq.sv
// Scoreboard bench for multdiv_seq (WIDTH=32): directed corner cases plus random operations
// checked against an arithmetic reference model.
module tb_multdiv_seq;

    typedef struct {
        logic [31:0] res;
        logic [31:0] rem;
        logic        exc;
        int          lat;
        int          due;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic        ctrl_SIGNED;
    logic [31:0] data_result;
    logic [31:0] data_remainder;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    int   nchk;
    int   nerr;
    int   cyc;
    exp_t sb[$];
    exp_t mon_e;
    logic have_last;
    logic [31:0] last_res;
    logic [31:0] last_rem;
    logic        last_exc;

    multdiv_seq #(.WIDTH(32)) dut (
        .clock          (clk),
        .reset          (reset),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .ctrl_SIGNED    (ctrl_SIGNED),
        .data_result    (data_result),
        .data_remainder (data_remainder),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Reference: plain integer arithmetic on 64-bit values.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic m, input logic s);
        exp_t        e;
        longint      sa, sb2, q, r;
        logic [63:0] pu;
        logic [31:0] lo;
        e.lat = 33;
        e.due = 0;
        e.rem = 32'h0;
        sa  = s ? longint'($signed(a)) : longint'(a);
        sb2 = s ? longint'($signed(b)) : longint'(b);
        if (m) begin
            if (s) begin
                q = sa * sb2;
                lo = q[31:0];
                e.res = lo;
                e.exc = (q != longint'($signed(lo)));
            end else begin
                pu = {32'h0, a} * {32'h0, b};
                e.res = pu[31:0];
                e.exc = (pu[63:32] != 32'h0);
            end
        end else if (b == 32'h0) begin
            e.res = 32'h0;
            e.rem = a;
            e.exc = 1'b1;
            e.lat = 0;
        end else begin
            q = sa / sb2;
            r = sa % sb2;
            lo = q[31:0];
            e.res = lo;
            e.rem = r[31:0];
            e.exc = s && (q != longint'($signed(lo)));
        end
        return e;
    endfunction

    function automatic exp_t lit(input logic [31:0] res, input logic [31:0] rem,
                                 input logic exc, input int lat);
        exp_t e;
        e.res = res;
        e.rem = rem;
        e.exc = exc;
        e.lat = lat;
        e.due = 0;
        return e;
    endfunction

    function automatic logic [31:0] pick();
        logic [31:0] v;
        case ($urandom_range(0, 6))
            0:       v = 32'h0;
            1:       v = 32'h8000_0000;
            2:       v = 32'hFFFF_FFFF;
            3:       v = 32'($urandom_range(1, 20));
            4:       v = 32'h0 - 32'($urandom_range(1, 20));
            5:       v = 32'($urandom_range(0, 65535));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            nchk++;
            nerr++;
            $display("FAIL busy_timeout: busy still 1 after %0d cycles", n);
        end
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic m,
                          input logic d, input logic s, input exp_t e);
        exp_t e2;
        wait_idle();
        if (have_last) begin
            chk("hold_result", data_result, last_res);
            chk("hold_remainder", data_remainder, last_rem);
            chk("hold_exception", 32'(data_exception), 32'(last_exc));
        end
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        ctrl_SIGNED   = s;
        @(posedge clk);
        #1;
        e2 = e;
        e2.due = cyc + e.lat;
        sb.push_back(e2);
        chk("busy_after_start", 32'(busy), 32'd1);
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
    endtask

    always @(negedge clk) begin
        if (data_resultRDY) begin
            if (sb.size() == 0) begin
                nchk++;
                nerr++;
                $display("FAIL unexpected_rdy: data_resultRDY=1 with nothing outstanding (cycle %0d)", cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("result", data_result, mon_e.res);
                chk("remainder", data_remainder, mon_e.rem);
                chk("exception", 32'(data_exception), 32'(mon_e.exc));
                chk("rdy_cycle", 32'(cyc), 32'(mon_e.due));
                chk("busy_at_rdy", 32'(busy), 32'd1);
                last_res  = mon_e.res;
                last_rem  = mon_e.rem;
                last_exc  = mon_e.exc;
                have_last = 1'b1;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, b;
        logic        m, d, s;
        int          sel;
        int          n;
        nchk = 0;
        nerr = 0;
        cyc = 0;
        have_last = 1'b0;
        last_res = 32'h0;
        last_rem = 32'h0;
        last_exc = 1'b0;
        reset = 1'b1;
        data_operandA = 32'h0;
        data_operandB = 32'h0;
        ctrl_MULT = 1'b0;
        ctrl_DIV = 1'b0;
        ctrl_SIGNED = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_result", data_result, 32'h0);
        chk("reset_remainder", data_remainder, 32'h0);
        chk("reset_exception", 32'(data_exception), 32'h0);
        chk("reset_rdy", 32'(data_resultRDY), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        @(negedge clk);
        reset = 1'b0;

        run_op(32'd7, 32'hFFFF_FFFA, 1'b1, 1'b0, 1'b1, lit(32'hFFFF_FFD6, 32'h0, 1'b0, 33));
        run_op(32'h0001_0000, 32'h0001_0000, 1'b1, 1'b0, 1'b0, lit(32'h0, 32'h0, 1'b1, 33));
        run_op(32'h7FFF_FFFF, 32'd2, 1'b1, 1'b0, 1'b1, lit(32'hFFFF_FFFE, 32'h0, 1'b1, 33));
        run_op(32'hFFFF_FFF9, 32'd2, 1'b0, 1'b1, 1'b1, lit(32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 33));
        run_op(32'd100, 32'd7, 1'b0, 1'b1, 1'b0, lit(32'd14, 32'd2, 1'b0, 33));
        run_op(32'd5, 32'd0, 1'b0, 1'b1, 1'b0, lit(32'h0, 32'd5, 1'b1, 0));
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1, lit(32'h8000_0000, 32'h0, 1'b1, 33));
        run_op(32'd3, 32'd4, 1'b1, 1'b1, 1'b0, lit(32'd12, 32'h0, 1'b0, 33));
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, lit(32'd1, 32'h0, 1'b1, 33));
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, lit(32'h8000_0000, 32'h0, 1'b1, 33));
        run_op(32'h8000_0000, 32'd1, 1'b1, 1'b0, 1'b1, lit(32'h8000_0000, 32'h0, 1'b0, 33));

        // A divide strobe with new operands mid-multiply must not disturb it.
        run_op(32'd1234, 32'd5678, 1'b1, 1'b0, 1'b0, lit(32'd7006652, 32'h0, 1'b0, 33));
        repeat (5) @(negedge clk);
        data_operandA = 32'd99;
        data_operandB = 32'd3;
        ctrl_DIV = 1'b1;
        ctrl_SIGNED = 1'b1;
        @(negedge clk);
        ctrl_DIV = 1'b0;
        wait_idle();

        // Reset 10 cycles into a multiply, with a coincident start strobe.
        data_operandA = 32'd11;
        data_operandB = 32'd13;
        ctrl_MULT = 1'b1;
        ctrl_SIGNED = 1'b0;
        @(negedge clk);
        ctrl_MULT = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        ctrl_MULT = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_result", data_result, 32'h0);
        chk("abort_remainder", data_remainder, 32'h0);
        chk("abort_exception", 32'(data_exception), 32'h0);
        chk("abort_rdy", 32'(data_resultRDY), 32'h0);
        chk("abort_busy", 32'(busy), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        ctrl_MULT = 1'b0;
        repeat (45) @(negedge clk);
        chk("abort_idle_busy", 32'(busy), 32'h0);
        chk("abort_idle_result", data_result, 32'h0);
        last_res = 32'h0;
        last_rem = 32'h0;
        last_exc = 1'b0;

        for (int i = 0; i < 60; i++) begin
            a = pick();
            b = pick();
            s = 1'($urandom_range(0, 1));
            sel = int'($urandom_range(0, 3));
            m = (sel == 0) || (sel == 2);
            d = (sel != 0);
            run_op(a, b, m, d, s, model(a, b, m, s));
        end

        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("queue_drained", 32'(sb.size()), 32'h0);
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/multdiv_seq.md
MULTDIV_SEQ -- requirements
Module: multdiv_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width, legal range 8..64, even.
REQ-002 SHALL have parameter CNT_W, default $clog2(WIDTH+1), width of the iteration counter.
REQ-003 SHALL have port clock  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports data_operandA, data_operandB  input  WIDTH  operands; A is multiplicand/dividend, B is multiplier/divisor.
REQ-006 SHALL have port ctrl_MULT  input  1  start-multiply strobe.
REQ-007 SHALL have port ctrl_DIV  input  1  start-divide strobe.
REQ-008 SHALL have port ctrl_SIGNED  input  1  1 = two's-complement operation, 0 = unsigned; sampled with the start strobe.
REQ-009 SHALL have port data_result  output  WIDTH  low WIDTH bits of product, or quotient.
REQ-010 SHALL have port data_remainder  output  WIDTH  division remainder; 0 after a multiply.
REQ-011 SHALL have port data_exception  output  1  overflow or divide-by-zero for the completed operation.
REQ-012 SHALL have port data_resultRDY  output  1  one-cycle completion pulse.
REQ-013 SHALL have port busy  output  1  high from the capture edge until the cycle data_resultRDY is high, inclusive.

Function
REQ-014 SHALL implement FSM states IDLE, MULT, DIV, DONE; DONE always returns to IDLE on the next edge.
REQ-015 In IDLE, a start strobe sampled high at edge E0 SHALL latch the operands, ctrl_SIGNED and the opcode, clear the counter, and enter MULT or DIV.
REQ-016 If ctrl_MULT and ctrl_DIV are both high at E0, multiply SHALL win.
REQ-017 Strobes while busy is high SHALL be ignored; latched operands SHALL NOT change.
REQ-018 MULT and DIV SHALL each perform exactly WIDTH one-bit iterations, on edges E0+1..E0+WIDTH.
REQ-019 The FSM SHALL enter DONE at edge E0+WIDTH+1; data_resultRDY SHALL be high for exactly the following cycle.
REQ-020 Multiply SHALL use radix-2 Booth encoding when signed, and shift-add when unsigned, with a 2*WIDTH-bit product register.
REQ-021 Multiply exception SHALL be set when the full product is not representable in WIDTH bits: signed means the upper WIDTH+1 bits are not all equal; unsigned means the upper WIDTH bits are nonzero.
REQ-022 Divide SHALL use a restoring algorithm on magnitudes; quotient sign = signA XOR signB; remainder sign = signA (truncating division).
REQ-023 Divide with B == 0 SHALL enter DONE directly at E0, skipping iteration, with data_result=0, data_remainder=A and data_exception=1.
REQ-024 A signed divide of the most-negative value by -1 SHALL complete at normal latency with data_result=most-negative, data_remainder=0 and data_exception=1.
REQ-025 data_result, data_remainder and data_exception SHALL update only on entry to DONE and SHALL hold until the next DONE.
REQ-026 Arithmetic SHALL wrap modulo 2^WIDTH; no saturation.

Reset
REQ-027 Reset sampled high SHALL force IDLE and clear all outputs and internal registers to 0, including mid-operation; the aborted operation SHALL produce no data_resultRDY.
REQ-028 A strobe coincident with reset SHALL be ignored; the first start is accepted at the first edge with reset low.

Structure
REQ-029 Package multdiv_pkg SHALL hold the state enum (IDLE/MULT/DIV/DONE) and the opcode constants OP_MULT and OP_DIV.
REQ-030 The iteration counter SHALL be a sub-module step_counter (CNT_W wide, synchronous clear and enable, terminal-count output at WIDTH-1); all remaining logic SHALL live in multdiv_seq.

Verification (WIDTH=32)
REQ-031 Signed multiply 7 x -6 -> data_result=0xFFFFFFD6, exception=0, data_resultRDY pulses one cycle, 33 cycles after the capture edge.
REQ-032 Unsigned multiply 0x00010000 x 0x00010000 -> data_result=0, exception=1; signed multiply 0x7FFFFFFF x 2 -> data_result=0xFFFFFFFE, exception=1.
REQ-033 Signed divide -7 / 2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; unsigned divide 100 / 7 -> quotient 14, remainder 2; exception=0 for both.
REQ-034 Divide 5 / 0 -> data_resultRDY in the cycle after the capture edge; data_result=0, data_remainder=5, exception=1.
REQ-035 Signed divide 0x80000000 / 0xFFFFFFFF -> data_result=0x80000000, data_remainder=0, exception=1.
REQ-036 Reset asserted 10 cycles into a multiply -> no data_resultRDY, outputs read 0; ctrl_DIV pulsed mid-multiply -> ignored, multiply result unchanged.
